mem32_reader: RTL and testbench
===============================

# mem32_reader

Read-side companion to the `mem32` byte memory. On a `start` request it issues four byte reads (addresses 0–3) to the memory's byte read port. It assembles the returned bytes into one 32-bit word, presents the word with a one-cycle `done` pulse, and holds it until the next completion. It sits between `mem32` and any 32-bit consumer, completing the round trip for words written through `mem32`'s 32-bit `Indata` port.

## Interface
- `READ_LAT`, default 1: memory read latency in cycles, counted from the sampling edge of `mem_rd`/`mem_addr` to the edge where `mem_data` is captured. Legal range 1–3.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request one word read; sampled only in IDLE.
- `mem_valid` input 1: `mem32` valid flag; memory holds a complete word.
- `mem_rd` output 1: byte read strobe to `mem32`.
- `mem_addr` output 2: byte address to `mem32`.
- `mem_data` input 8: byte returned by `mem32`.
- `Outdata` output 32: assembled word.
- `done` output 1: one-cycle pulse; `Outdata` is updated in the same cycle.
- `busy` output 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `busy`=0, `mem_rd`=0.
  - WAIT_VALID: waiting for the memory to hold a word.
  - ISSUE: four cycles; `mem_rd`=1 with `mem_addr` = 0, 1, 2, 3 on consecutive cycles.
  - DRAIN: waiting for outstanding bytes.
  - DONE: one cycle; `done`=1.
- Transitions:
  - IDLE → ISSUE when `start`=1 and `mem_valid`=1.
  - IDLE → WAIT_VALID when `start`=1 and `mem_valid`=0.
  - WAIT_VALID → ISSUE when `mem_valid`=1.
  - ISSUE → DRAIN after the addr-3 issue cycle.
  - DRAIN → DONE when the fourth byte is captured.
  - DONE → IDLE.
- Reads are pipelined. A READ_LAT-deep tag shift register tracks in-flight bytes by address. Each byte is captured into its lane in a shadow register when its tag emerges.
- Byte order is big-endian: addr 0 → `Outdata[31:24]`, addr 3 → `Outdata[7:0]`. This matches `mem32`, where `Indata` 32'hA1B2C3D4 reads back as A1, B2, C3, D4 from addr 0–3.
- `Outdata` loads from the shadow register only on entry to DONE. It holds between completions and never shows a partial word.
- `start` is ignored while `busy`=1; it is not queued.
- `mem_valid` is checked only at start/WAIT_VALID. If it drops mid-transaction, the transaction continues unchanged.
- `mem_addr` = 0 whenever `mem_rd`=0.

## Timing
- Reset values: `Outdata`=32'h0, `done`=0, `busy`=0, `mem_rd`=0, `mem_addr`=2'b00, state IDLE, shadow register and tags cleared.
- Let `start` be sampled high at edge E0 with `mem_valid`=1:
  - `mem_rd`=1 in the cycles following edges E0–E3 (addr 0–3).
  - Byte k is captured at edge E(k+1+READ_LAT−1)+1, i.e. E(k+READ_LAT+1).
  - `done` and the new `Outdata` are valid in the cycle following edge E(4+READ_LAT).
  - With READ_LAT=1: `done` rises 5 edges after E0 and `busy` falls one cycle later.
- Back-to-back: the earliest accepted `start` is in the cycle after DONE (IDLE). The minimum period is 6+READ_LAT cycles.
- WAIT_VALID adds exactly N cycles, where N is the number of cycles `mem_valid` stays low.
- `rst` mid-transaction: at the next edge all outputs return to their reset values. In-flight tags are discarded and late `mem_data` is ignored. `done` does not pulse.
- `rst` and `start` high together: reset wins.

## Configuration
- `MEM32_READER_LE_EN` defined: little-endian assembly. Addr 0 → `Outdata[7:0]`, addr 3 → `Outdata[31:24]`. 32'hA1B2C3D4 in memory reads out as 32'hD4C3B2A1.
- Not defined: big-endian as specified above. All other behaviour and timing are identical in both builds.

## Test plan
- Reset, then write 32'hA1B2C3D4 into `mem32` until `mem_valid`=1, then pulse `start` (READ_LAT=1) → `mem_addr` sequence 0,1,2,3 with `mem_rd`=1; `done` pulses 5 edges after `start`; `Outdata`=32'hA1B2C3D4.
- `start` with `mem_valid`=0, raise `mem_valid` 3 cycles later → no `mem_rd` until `mem_valid` rises; `done` is delayed by exactly 3 cycles; `Outdata` is correct.
- Two words, 32'h11223344 then 32'h55667788, back-to-back starts, second `start` also driven while `busy`=1 → the busy-time `start` is ignored; `Outdata` stays 32'h11223344 until the second `done`, then becomes 32'h55667788.
- `rst` asserted during ISSUE (after addr 1) → next edge: `mem_rd`=0, `busy`=0, `Outdata`=0; no `done` pulse; a fresh `start` then completes normally.
- READ_LAT=3 with a delayed memory model, data 32'hDEADBEEF → `done` rises 7 edges after `start`; `Outdata`=32'hDEADBEEF.
- Build with `MEM32_READER_LE_EN`, memory holding A1B2C3D4 → `Outdata`=32'hD4C3B2A1 with the same cycle timing as the big-endian build.

Source files
------------

// File: rtl/mem32_reader.sv
// Word reader for the mem32 byte memory: four pipelined byte reads assembled into Outdata.
// Define MEM32_READER_LE_EN for little-endian lane order; big-endian when it is undefined.
module mem32_reader #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_valid,
    output logic        mem_rd,
    output logic [1:0]  mem_addr,
    input  logic [7:0]  mem_data,
    output logic [31:0] Outdata,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, WAIT_VALID, ISSUE, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [READ_LAT-1:0]        tag_vld_q, tag_vld_d;
    logic [READ_LAT-1:0][1:0]   tag_addr_q, tag_addr_d;
    logic [31:0]                shadow_q, shadow_d;
    logic [31:0]                out_q, out_d;
    logic                       cap;
    logic [1:0]                 cap_addr;
    logic [1:0]                 lane;

    assign Outdata = out_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        mem_rd   = 1'b0;
        mem_addr = 2'b00;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);

        // The oldest tag marks the byte arriving on mem_data this cycle.
        cap      = tag_vld_q[READ_LAT-1];
        cap_addr = tag_addr_q[READ_LAT-1];
`ifdef MEM32_READER_LE_EN
        lane     = cap_addr;
`else
        lane     = ~cap_addr;
`endif
        shadow_d = shadow_q;
        if (cap) shadow_d[8*lane +: 8] = mem_data;

        case (state_q)
            IDLE: begin
                cnt_d = 2'd0;
                if (start) state_d = mem_valid ? ISSUE : WAIT_VALID;
            end
            WAIT_VALID: begin
                if (mem_valid) state_d = ISSUE;
            end
            ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = cnt_q;
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = DRAIN;
            end
            DRAIN: begin
                // Merge the final byte on the same edge so Outdata never shows a partial word.
                if (cap && cap_addr == 2'd3) begin
                    state_d = DONE;
                    out_d   = shadow_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tag_vld_d[0]  = mem_rd;
        tag_addr_d[0] = mem_addr;
        for (int i = 1; i < READ_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_addr_d[i] = tag_addr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            tag_vld_q  <= '0;
            tag_addr_q <= '0;
            shadow_q   <= 32'h0;
            out_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_addr_q <= tag_addr_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_mem32_reader.sv
// Scoreboard bench for mem32_reader: READ_LAT=1 and READ_LAT=3 instances share stimulus,
// each fed by its own delayed byte-memory model; expected words/edges come from transaction arithmetic.
module tb_mem32_reader;

    typedef struct {
        logic [31:0] word;
        int          d;
    } exp_t;

    localparam int BIG = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst, start, mem_valid;
    logic [31:0] mem_word;
    logic        mem_rd [2];
    logic [1:0]  mem_addr [2];
    logic [7:0]  mem_data [2];
    logic [31:0] outdata [2];
    logic        done [2];
    logic        busy [2];
    logic [7:0]  pipe [2][3];

    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    bit   en = 0, fin = 0, fin_done = 0;
    int   rst_edge = -1;
    int   free_at [2];
    bit   cur_v [2];
    int   cur_c [2], cur_e [2], cur_d [2], cur_r [2];
    logic [31:0] held [2];
    exp_t q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem32_reader #(.READ_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mem_valid(mem_valid),
        .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
        .Outdata(outdata[0]), .done(done[0]), .busy(busy[0]));

    mem32_reader #(.READ_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mem_valid(mem_valid),
        .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
        .Outdata(outdata[1]), .done(done[1]), .busy(busy[1]));

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // mem32 byte order: addr 0 holds the most significant byte of the written word.
    function automatic logic [7:0] mem_byte(input logic [31:0] w, input logic [1:0] a);
        logic [31:0] s;
        s = w >> (8 * (3 - int'(a)));
        return s[7:0];
    endfunction

    function automatic logic [31:0] expw(input logic [31:0] w);
`ifdef MEM32_READER_LE_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Memory with a 1- or 3-cycle read pipeline; idle slots carry junk.
    assign mem_data[0] = pipe[0][0];
    assign mem_data[1] = pipe[1][2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
            pipe[i][0] <= mem_rd[i] ? mem_byte(mem_word, mem_addr[i]) : 8'($urandom);
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    // Monitor: outputs seen in the cycle following edge number cyc.
    always @(negedge clk) begin
        if (en) begin
            for (int i = 0; i < 2; i++) begin
                bit   act, busy_e, rd_e, done_e;
                int   addr_e;
                exp_t w;
                if (cyc == rst_edge) begin
                    q[i].delete();
                    held[i] = 32'h0;
                end
                act    = cur_v[i] && (cyc < cur_r[i]);
                busy_e = act && cyc >= cur_c[i] && cyc <= cur_d[i];
                rd_e   = act && cyc >= cur_e[i] && cyc <= cur_e[i] + 3;
                addr_e = rd_e ? cyc - cur_e[i] : 0;
                done_e = act && cyc == cur_d[i];
                if (done[i] === 1'b1) begin
                    if (q[i].size() == 0) begin
                        chk("unexpected_done", i, 32'd1, 32'd0);
                    end else begin
                        w = q[i].pop_front();
                        chk("done_edge", i, cyc, w.d);
                        held[i] = w.word;
                    end
                end
                chk("busy", i, {31'd0, busy[i]}, {31'd0, busy_e});
                chk("done", i, {31'd0, done[i]}, {31'd0, done_e});
                chk("mem_rd", i, {31'd0, mem_rd[i]}, {31'd0, rd_e});
                chk("mem_addr", i, {30'd0, mem_addr[i]}, 32'(addr_e));
                chk("Outdata", i, outdata[i], held[i]);
            end
            if (fin && !fin_done) begin
                fin_done = 1;
                for (int i = 0; i < 2; i++) chk("pending_words", i, q[i].size(), 0);
            end
        end
    end

    task automatic do_txn(input logic [31:0] word, input int nlow, input bit extra,
                          input bit drop, input int rst_off, input bit b2b);
        int c, e, xs, tgt;
        bit acc [2];
        tgt = b2b ? free_at[0] : ((free_at[0] > free_at[1]) ? free_at[0] : free_at[1]);
        if (!b2b) tgt += $urandom_range(0, 2);
        while (cyc + 1 < tgt) begin @(posedge clk); #1; end
        mem_word  = word;
        start     = 1'b1;
        mem_valid = (nlow == 0);
        c  = cyc + 1;
        e  = c + nlow;
        xs = $urandom_range(1, 6);
        for (int i = 0; i < 2; i++) begin
            acc[i] = (c >= free_at[i]);
            if (acc[i]) begin
                cur_v[i] = 1; cur_c[i] = c; cur_e[i] = e;
                cur_d[i] = e + 4 + lat(i); cur_r[i] = BIG;
                q[i].push_back(exp_t'{expw(word), e + 4 + lat(i)});
                free_at[i] = e + 6 + lat(i);
            end
        end
        while (cyc + 1 < e + 7) begin
            @(posedge clk); #1;
            start = extra && acc[0] && acc[1] && (cyc + 1 == c + xs);
            rst   = 1'b0;
            if (cyc + 1 == e) mem_valid = 1'b1;
            if (drop && cyc + 1 == e + 1) mem_valid = 1'b0;
            if (drop && cyc + 1 == e + 3) mem_valid = 1'b1;
            if (rst_off > 0 && cyc + 1 == e + rst_off) begin
                rst      = 1'b1;
                rst_edge = cyc + 1;
                for (int i = 0; i < 2; i++) begin
                    cur_r[i]   = cyc + 1;
                    free_at[i] = cyc + 2;
                end
            end
        end
        start     = 1'b0;
        rst       = 1'b0;
        mem_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_valid = 1'b1; mem_word = 32'h0;
        for (int i = 0; i < 2; i++) begin
            cur_v[i] = 0; cur_r[i] = BIG; held[i] = 32'h0;
            for (int k = 0; k < 3; k++) pipe[i][k] = 8'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1;
        for (int i = 0; i < 2; i++) free_at[i] = cyc + 1;
        repeat (2) @(posedge clk);
        #1;

        do_txn(32'hA1B2C3D4, 0, 0, 0, 0, 0);
        do_txn(32'hCAFEF00D, 3, 0, 0, 0, 0);
        do_txn(32'h11223344, 0, 1, 0, 0, 0);
        do_txn(32'h55667788, 0, 0, 0, 0, 1);
        do_txn(32'h0BADF00D, 0, 0, 0, 2, 0);
        do_txn(32'h600DD00D, 0, 0, 0, 0, 0);
        do_txn(32'hDEADBEEF, 0, 0, 1, 0, 0);
        for (int n = 0; n < 24; n++) begin
            bit b2b, extra, drop;
            int ro;
            b2b   = ($urandom_range(0, 3) == 0);
            ro    = ($urandom_range(0, 5) == 0 && !b2b) ? $urandom_range(1, 4) : 0;
            extra = !b2b && ro == 0 && $urandom_range(0, 1) == 1;
            drop  = ($urandom_range(0, 2) == 0);
            do_txn($urandom, b2b ? 0 : $urandom_range(0, 4), extra, drop, ro, b2b);
        end

        while (cyc < ((free_at[0] > free_at[1]) ? free_at[0] : free_at[1]) + 2) begin
            @(posedge clk); #1;
        end
        fin = 1;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
